// File: rtl/apb2axi_pkg.sv
// Shared APB-to-AXI bridge types: directory entry layout, scheduler state
// encoding and default outstanding-command limits.
package apb2axi_pkg;

    localparam int TAG_W                = 4;
    localparam int APB2AXI_MAX_RD_OUTST = 4;
    localparam int APB2AXI_MAX_WR_OUTST = 4;

    typedef struct packed {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } directory_entry_t;

    typedef enum logic {
        SCHED_IDLE  = 1'b0,
        SCHED_ISSUE = 1'b1
    } sched_state_t;

endpackage

// File: rtl/apb2axi_credit_cnt.sv
// Outstanding-command credit counter: counts issued commands, retires them on
// completion, and flags (sticky) a completion that arrives with nothing outstanding.
module apb2axi_credit_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    input  logic [3:0] max,
    output logic [3:0] count,
    output logic       can_take,
    output logic       underflow
);

    logic [3:0] count_q, count_d;
    logic       underflow_q, underflow_d;

    always_comb begin
        count_d     = count_q;
        underflow_d = underflow_q;
        if (dec && (count_q == 4'd0)) begin
            underflow_d = 1'b1;
        end
        // Simultaneous issue and completion cancel out.
        if (inc && !dec) begin
            if (count_q < max) begin
                count_d = count_q + 4'd1;
            end
        end else if (dec && !inc) begin
            if (count_q != 4'd0) begin
                count_d = count_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 4'd0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign can_take  = (count_q < max);
    assign underflow = underflow_q;

endmodule

// File: rtl/apb2axi_txn_sched.sv
// In-order scheduler: pops PENDING directory heads when credit allows and
// presents them to the read or write issuer. APB2AXI_SCHED_TIMEOUT_EN adds a handshake timeout flag.
module apb2axi_txn_sched
    import apb2axi_pkg::*;
#(
    parameter int TAG_W_P      = TAG_W,
    parameter int MAX_RD_OUTST = APB2AXI_MAX_RD_OUTST,
    parameter int MAX_WR_OUTST = APB2AXI_MAX_WR_OUTST
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic               pending_valid,
    input  directory_entry_t   pending_entry,
    input  logic [TAG_W_P-1:0] pending_tag,
    output logic               pending_pop,
    output logic               rd_cmd_valid,
    input  logic               rd_cmd_ready,
    output logic               wr_cmd_valid,
    input  logic               wr_cmd_ready,
    output directory_entry_t   cmd_entry,
    output logic [TAG_W_P-1:0] cmd_tag,
    input  logic               cpl_valid,
    input  logic               cpl_is_write,
    output logic [3:0]         rd_outst,
    output logic [3:0]         wr_outst,
    output logic               sched_busy,
    output logic               cpl_underflow,
    output logic               issue_timeout
);

    sched_state_t       state_q, state_d;
    directory_entry_t   cmd_entry_q, cmd_entry_d;
    logic [TAG_W_P-1:0] cmd_tag_q, cmd_tag_d;

    logic pop;
    logic rd_hs, wr_hs;
    logic head_credit;
    logic rd_can_take, wr_can_take;
    logic rd_underflow, wr_underflow;

    always_comb begin
        state_d      = state_q;
        cmd_entry_d  = cmd_entry_q;
        cmd_tag_d    = cmd_tag_q;
        pop          = 1'b0;
        rd_cmd_valid = 1'b0;
        wr_cmd_valid = 1'b0;
        rd_hs        = 1'b0;
        wr_hs        = 1'b0;
        head_credit  = pending_entry.is_write ? wr_can_take : rd_can_take;
        case (state_q)
            SCHED_IDLE: begin
                // Credit is judged only here; the head is never bypassed.
                if (pending_valid && head_credit) begin
                    pop         = 1'b1;
                    cmd_entry_d = pending_entry;
                    cmd_tag_d   = pending_tag;
                    state_d     = SCHED_ISSUE;
                end
            end
            SCHED_ISSUE: begin
                if (cmd_entry_q.is_write) begin
                    wr_cmd_valid = 1'b1;
                    wr_hs        = wr_cmd_ready;
                end else begin
                    rd_cmd_valid = 1'b1;
                    rd_hs        = rd_cmd_ready;
                end
                if (rd_hs || wr_hs) begin
                    state_d = SCHED_IDLE;
                end
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= SCHED_IDLE;
            cmd_entry_q <= '0;
            cmd_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_entry_q <= cmd_entry_d;
            cmd_tag_q   <= cmd_tag_d;
        end
    end

    // The pop is combinational, so it is also masked while reset is held.
    assign pending_pop = pop && presetn;
    assign cmd_entry   = cmd_entry_q;
    assign cmd_tag     = cmd_tag_q;

    apb2axi_credit_cnt u_rd_credit (
        .clk       (pclk),
        .rst_n     (presetn),
        .inc       (rd_hs),
        .dec       (cpl_valid && !cpl_is_write),
        .max       (4'(MAX_RD_OUTST)),
        .count     (rd_outst),
        .can_take  (rd_can_take),
        .underflow (rd_underflow)
    );

    apb2axi_credit_cnt u_wr_credit (
        .clk       (pclk),
        .rst_n     (presetn),
        .inc       (wr_hs),
        .dec       (cpl_valid && cpl_is_write),
        .max       (4'(MAX_WR_OUTST)),
        .count     (wr_outst),
        .can_take  (wr_can_take),
        .underflow (wr_underflow)
    );

    assign cpl_underflow = rd_underflow || wr_underflow;
    assign sched_busy    = (state_q != SCHED_IDLE) || (rd_outst != 4'd0) || (wr_outst != 4'd0);

`ifdef APB2AXI_SCHED_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       issue_timeout_q, issue_timeout_d;

    // Flag is raised on the same edge the stall counter reaches 255.
    always_comb begin
        tmo_cnt_d       = 8'd0;
        issue_timeout_d = issue_timeout_q;
        if ((state_q == SCHED_ISSUE) && !(rd_hs || wr_hs)) begin
            tmo_cnt_d = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
            if (tmo_cnt_q == 8'd254) begin
                issue_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tmo_cnt_q       <= 8'd0;
            issue_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q       <= tmo_cnt_d;
            issue_timeout_q <= issue_timeout_d;
        end
    end

    assign issue_timeout = issue_timeout_q;
`else
    assign issue_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb2axi_txn_sched.sv
// Bench for apb2axi_txn_sched: randomized and directed traffic against an
// in-order transaction model with a command scoreboard.
module tb_apb2axi_txn_sched;
    import apb2axi_pkg::*;

    typedef struct packed {
        directory_entry_t   e;
        logic [TAG_W-1:0]   t;
    } txn_t;

    localparam int W      = $bits(txn_t);
    localparam int MAX_RD = APB2AXI_MAX_RD_OUTST;
    localparam int MAX_WR = APB2AXI_MAX_WR_OUTST;

    logic             pclk;
    logic             presetn;
    logic             pending_valid;
    directory_entry_t pending_entry;
    logic [TAG_W-1:0] pending_tag;
    logic             pending_pop;
    logic             rd_cmd_valid;
    logic             rd_cmd_ready;
    logic             wr_cmd_valid;
    logic             wr_cmd_ready;
    directory_entry_t cmd_entry;
    logic [TAG_W-1:0] cmd_tag;
    logic             cpl_valid;
    logic             cpl_is_write;
    logic [3:0]       rd_outst;
    logic [3:0]       wr_outst;
    logic             sched_busy;
    logic             cpl_underflow;
    logic             issue_timeout;

    apb2axi_txn_sched dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .pending_valid (pending_valid),
        .pending_entry (pending_entry),
        .pending_tag   (pending_tag),
        .pending_pop   (pending_pop),
        .rd_cmd_valid  (rd_cmd_valid),
        .rd_cmd_ready  (rd_cmd_ready),
        .wr_cmd_valid  (wr_cmd_valid),
        .wr_cmd_ready  (wr_cmd_ready),
        .cmd_entry     (cmd_entry),
        .cmd_tag       (cmd_tag),
        .cpl_valid     (cpl_valid),
        .cpl_is_write  (cpl_is_write),
        .rd_outst      (rd_outst),
        .wr_outst      (wr_outst),
        .sched_busy    (sched_busy),
        .cpl_underflow (cpl_underflow),
        .issue_timeout (issue_timeout)
    );

    // ---------------- clock / reset ----------------
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, need end");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, need 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Directory contents awaiting pop, and commands expected on the issue ports.
    txn_t           pend_q[$];
    logic [W-1:0]   exp_q[$];

    // Reference model state.
    bit inflight   = 1'b0;
    bit inflight_w = 1'b0;
    int rd_m       = 0;
    int wr_m       = 0;
    bit und_m      = 1'b0;
    bit tmo_m      = 1'b0;
    int stall      = 0;
    bit pop_seen   = 1'b0;

    // ---------------- driver tasks ----------------
    task automatic refresh();
        if (pend_q.size() != 0) begin
            pending_valid = 1'b1;
            pending_entry = pend_q[0].e;
            pending_tag   = pend_q[0].t;
        end else begin
            pending_valid = 1'b0;
            pending_entry = '0;
            pending_tag   = '0;
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
        if (pop_seen && pend_q.size() != 0) begin
            void'(pend_q.pop_front());
        end
        pop_seen = 1'b0;
        refresh();
    endtask

    task automatic push_entry(input bit w, input logic [31:0] addr, input logic [TAG_W-1:0] tag);
        txn_t x;
        x.e.is_write = w;
        x.e.addr     = addr;
        x.e.wdata    = $urandom;
        x.e.strb     = 4'($urandom_range(0, 15));
        x.t          = tag;
        pend_q.push_back(x);
        exp_q.push_back(x);
        refresh();
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (pend_q.size() == 0 && !inflight) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (pend_q.size() == 0 && !inflight) ok = 1'b1;
        check(name, 128'(ok), 128'(1));
    endtask

    task automatic drain_cpl(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rd_m == 0 && wr_m == 0) break;
            cpl_valid    = 1'b1;
            cpl_is_write = (rd_m == 0);
            tick();
        end
        cpl_valid    = 1'b0;
        cpl_is_write = 1'b0;
        check(name, 128'(rd_m + wr_m), 128'(0));
    endtask

    task automatic clear_model();
        pend_q.delete();
        exp_q.delete();
        inflight   = 1'b0;
        inflight_w = 1'b0;
        rd_m       = 0;
        wr_m       = 0;
        und_m      = 1'b0;
        tmo_m      = 1'b0;
        stall      = 0;
        pop_seen   = 1'b0;
        refresh();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge pclk) begin
        bit hd_w, exp_pop, hs, rd_inc, wr_inc, rd_dec, wr_dec;
        if (presetn) begin
            hd_w    = (pend_q.size() != 0) ? pend_q[0].e.is_write : 1'b0;
            exp_pop = (pend_q.size() != 0) && !inflight &&
                      (hd_w ? (wr_m < MAX_WR) : (rd_m < MAX_RD));

            check("pending_pop", 128'(pending_pop), 128'(exp_pop));
            check("rd_cmd_valid", 128'(rd_cmd_valid), 128'(inflight && !inflight_w));
            check("wr_cmd_valid", 128'(wr_cmd_valid), 128'(inflight && inflight_w));
            if (inflight && exp_q.size() != 0) begin
                check("cmd_entry_tag", 128'({cmd_entry, cmd_tag}), 128'(exp_q[0]));
            end
            check("rd_outst", 128'(rd_outst), 128'(rd_m));
            check("wr_outst", 128'(wr_outst), 128'(wr_m));
            check("cpl_underflow", 128'(cpl_underflow), 128'(und_m));
            check("issue_timeout", 128'(issue_timeout), 128'(tmo_m));
            check("sched_busy", 128'(sched_busy), 128'(inflight || rd_m != 0 || wr_m != 0));

            hs     = inflight && (inflight_w ? wr_cmd_ready : rd_cmd_ready);
            rd_inc = hs && !inflight_w;
            wr_inc = hs && inflight_w;
            rd_dec = cpl_valid && !cpl_is_write;
            wr_dec = cpl_valid && cpl_is_write;

`ifdef APB2AXI_SCHED_TIMEOUT_EN
            if (inflight && !hs) begin
                stall++;
                if (stall >= 255) tmo_m = 1'b1;
            end else begin
                stall = 0;
            end
`endif
            if ((rd_dec && rd_m == 0) || (wr_dec && wr_m == 0)) und_m = 1'b1;
            if (rd_inc && !rd_dec) rd_m++;
            else if (rd_dec && !rd_inc && rd_m > 0) rd_m--;
            if (wr_inc && !wr_dec) wr_m++;
            else if (wr_dec && !wr_inc && wr_m > 0) wr_m--;

            if (hs) begin
                inflight = 1'b0;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (exp_pop) begin
                inflight   = 1'b1;
                inflight_w = hd_w;
            end
            pop_seen = pending_pop;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit w;
        presetn       = 1'b0;
        rd_cmd_ready  = 1'b0;
        wr_cmd_ready  = 1'b0;
        cpl_valid     = 1'b0;
        cpl_is_write  = 1'b0;
        clear_model();

        // Reset state.
        #12;
        check("rst_pending_pop", 128'(pending_pop), 128'(0));
        check("rst_cmd_valid", 128'({rd_cmd_valid, wr_cmd_valid}), 128'(0));
        check("rst_outst", 128'({rd_outst, wr_outst}), 128'(0));
        check("rst_flags", 128'({sched_busy, cpl_underflow, issue_timeout}), 128'(0));
        check("rst_cmd", 128'({cmd_entry, cmd_tag}), 128'(0));
        @(posedge pclk);
        #1;
        presetn = 1'b1;

        // Randomized mixed traffic; completions only for outstanding commands.
        for (int i = 0; i < 600; i++) begin
            tick();
            if (pend_q.size() < 4 && $urandom_range(0, 1) == 1)
                push_entry(bit'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
            rd_cmd_ready = ($urandom_range(0, 3) != 0);
            wr_cmd_ready = ($urandom_range(0, 3) != 0);
            cpl_valid    = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                w = bit'($urandom_range(0, 1));
                if (w ? (wr_m > 0) : (rd_m > 0)) begin
                    cpl_valid    = 1'b1;
                    cpl_is_write = w;
                end
            end
        end
        cpl_valid    = 1'b0;
        rd_cmd_ready = 1'b1;
        wr_cmd_ready = 1'b1;
        wait_idle("rand_drain_issue", 100);
        drain_cpl("rand_drain_cpl", 50);
        tick();

        // Read head, tag 3, addr 0x1000, ready high.
        push_entry(1'b0, 32'h1000, 4'd3);
        tick();
        check("s1_rd_cmd_valid", 128'(rd_cmd_valid), 128'(1));
        check("s1_cmd_tag", 128'(cmd_tag), 128'(3));
        check("s1_cmd_addr", 128'(cmd_entry.addr), 128'(32'h1000));
        tick();
        check("s1_rd_outst", 128'(rd_outst), 128'(1));
        drain_cpl("s1_drain", 10);

        // Four writes fill credit; fifth write blocks, read behind it waits.
        for (int i = 0; i < 5; i++) push_entry(1'b1, 32'h2000 + 32'(i * 4), 4'(i));
        push_entry(1'b0, 32'h3000, 4'd9);
        repeat (20) tick();
        check("s2_wr_outst_full", 128'(wr_outst), 128'(4));
        check("s3_head_blocked", 128'(pend_q.size()), 128'(2));
        check("s3_no_read_bypass", 128'(rd_outst), 128'(0));
        cpl_valid    = 1'b1;
        cpl_is_write = 1'b1;
        tick();
        cpl_valid = 1'b0;
        wait_idle("s2_fifth_issue", 20);
        check("s2_wr_outst_after", 128'(wr_outst), 128'(4));
        check("s3_read_after", 128'(rd_outst), 128'(1));
        drain_cpl("s2_drain", 20);

        // Read handshake and read completion in the same cycle at rd_outst=2.
        push_entry(1'b0, 32'h4000, 4'd1);
        push_entry(1'b0, 32'h4004, 4'd2);
        wait_idle("s4_prefill", 20);
        tick();
        check("s4_rd_outst_pre", 128'(rd_outst), 128'(2));
        rd_cmd_ready = 1'b0;
        push_entry(1'b0, 32'h4008, 4'd5);
        for (int i = 0; i < 10; i++) begin
            if (rd_cmd_valid) break;
            tick();
        end
        check("s4_in_issue", 128'(rd_cmd_valid), 128'(1));
        rd_cmd_ready = 1'b1;
        cpl_valid    = 1'b1;
        cpl_is_write = 1'b0;
        tick();
        cpl_valid = 1'b0;
        check("s4_rd_outst_same", 128'(rd_outst), 128'(2));
        drain_cpl("s4_drain", 20);
        tick();

        // Write completion with nothing outstanding.
        cpl_valid    = 1'b1;
        cpl_is_write = 1'b1;
        tick();
        cpl_valid = 1'b0;
        check("s5_underflow", 128'(cpl_underflow), 128'(1));
        check("s5_wr_outst", 128'(wr_outst), 128'(0));
        repeat (5) tick();
        check("s5_underflow_sticky", 128'(cpl_underflow), 128'(1));

        // Stalled read for 300 cycles, then reset mid-ISSUE.
        rd_cmd_ready = 1'b0;
        push_entry(1'b0, 32'h5000, 4'd7);
        repeat (100) tick();
        check("s6_no_early_timeout", 128'(issue_timeout), 128'(0));
        push_entry(1'b0, 32'h5004, 4'd8);
        repeat (200) tick();
`ifdef APB2AXI_SCHED_TIMEOUT_EN
        check("s6_timeout", 128'(issue_timeout), 128'(1));
`else
        check("s6_timeout", 128'(issue_timeout), 128'(0));
`endif
        check("s6_still_valid", 128'(rd_cmd_valid), 128'(1));
        #2;
        presetn = 1'b0;
        #1;
        check("s6_rst_pop", 128'(pending_pop), 128'(0));
        check("s6_rst_valid", 128'({rd_cmd_valid, wr_cmd_valid}), 128'(0));
        check("s6_rst_outst", 128'({rd_outst, wr_outst}), 128'(0));
        check("s6_rst_flags", 128'({sched_busy, cpl_underflow, issue_timeout}), 128'(0));
        check("s6_rst_cmd", 128'({cmd_entry, cmd_tag}), 128'(0));
        clear_model();
        @(posedge pclk);
        @(posedge pclk);
        #1;
        presetn      = 1'b1;
        rd_cmd_ready = 1'b1;

        // Traffic resumes cleanly after reset.
        push_entry(1'b0, 32'h6000, 4'd4);
        push_entry(1'b1, 32'h6004, 4'd6);
        wait_idle("post_rst_issue", 20);
        tick();
        check("post_rst_outst", 128'({rd_outst, wr_outst}), 128'({4'd1, 4'd1}));
        drain_cpl("post_rst_drain", 10);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
